lsu_mc: RTL
===========

LSU_MC -- requirements
Module: lsu_mc

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning data-memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter MEM_LAT, default 2, meaning data-memory access wait cycles (1..7).
REQ-003 SHALL have parameter NUM_IO_OUT, default 5, meaning number of 32-bit output IO channels (1..8).
REQ-004 SHALL have port i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_req_valid  in  1  request present.
REQ-007 SHALL have port o_req_ready  out  1  request accepted this cycle when high together with i_req_valid.
REQ-008 SHALL have port i_addr  in  32  byte address.
REQ-009 SHALL have port i_wren  in  1  1 = store, 0 = load.
REQ-010 SHALL have port i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-011 SHALL have port i_unsigned  in  1  1 = zero-extend, 0 = sign-extend loads.
REQ-012 SHALL have port i_st_data  in  32  store data, right-aligned.
REQ-013 SHALL have port o_rsp_valid  out  1  one-cycle response pulse.
REQ-014 SHALL have port o_ld_data  out  32  load result, valid with o_rsp_valid.
REQ-015 SHALL have port o_misaligned  out  1  misalignment flag, valid with o_rsp_valid.
REQ-016 SHALL have port i_io_sw  in  32  asynchronous switch input.
REQ-017 SHALL have port o_io_out  out  NUM_IO_OUT*32  output channel registers, channel k at bits [32k+31:32k].

Function
REQ-018 SHALL decode the address map: addr[28]=0 selects data memory (word index addr[log2(MEM_WORDS)+1:2]); addr[28]=1 and addr[16]=1 selects switches; addr[28]=1 and addr[16]=0 selects IO channel addr[14:12].
REQ-019 SHALL implement FSM states IDLE, MEM_WAIT, RESP; o_req_ready is 1 only in IDLE.
REQ-020 SHALL latch addr, wren, size, unsigned and st_data on acceptance (valid & ready).
REQ-021 SHALL classify an access as misaligned when it is a half with addr[0]=1 or a word with addr[1:0]!=0; it then goes IDLE->RESP with o_misaligned=1, o_ld_data=0, and no state modified.
REQ-022 SHALL route IO and switch accesses IDLE->RESP, so o_rsp_valid asserts the cycle after acceptance.
REQ-023 SHALL route data-memory accesses IDLE->MEM_WAIT, count MEM_LAT cycles, then go to RESP, so o_rsp_valid asserts MEM_LAT+1 cycles after acceptance.
REQ-024 SHALL commit a memory store only on the last MEM_WAIT cycle, using byte mask: byte = 0001<<addr[1:0], half = 0011<<addr[1:0], word = 1111, with data shifted left by addr[1:0]*8.
REQ-025 SHALL write IO channel stores in the RESP-entry cycle under the same byte mask; stores to switches, or to channels >= NUM_IO_OUT, SHALL be dropped without error.
REQ-026 SHALL form load data by shifting the selected word right by addr[1:0]*8, then extending byte/half per i_unsigned.
REQ-027 SHALL return 0 for reads of channels >= NUM_IO_OUT, and SHALL return o_ld_data=0 for stores.
REQ-028 SHALL hold o_rsp_valid for exactly one cycle (RESP->IDLE unconditionally); o_ld_data and o_misaligned SHALL hold their values until the next response.
REQ-029 SHALL sample i_io_sw through a two-flop synchronizer; switch loads return the second-stage value.
REQ-030 SHALL ignore i_req_valid outside IDLE; a new request MAY be accepted in the cycle after RESP.

Reset
REQ-031 SHALL, on i_reset low, immediately set FSM=IDLE, wait counter=0, o_rsp_valid=0, o_ld_data=0, o_misaligned=0, all o_io_out=0 and synchronizer flops=0.
REQ-032 SHALL not reset memory contents; a store interrupted by reset before its commit cycle SHALL leave memory unchanged.

Structure
REQ-033 SHALL place the size encoding, the FSM state enum and the address-map bit positions in package lsu_pkg.
REQ-034 SHALL implement the byte-masked memory array as sub-module lsu_dmem.

Verification
REQ-035 Store word 0xDEADBEEF to 0x100, load byte unsigned from 0x103 -> o_ld_data=0x000000DE at MEM_LAT+1 cycles after acceptance (3 with default).
REQ-036 Load half signed from 0x102 after REQ-035 -> o_ld_data=0xFFFFDEAD.
REQ-037 Store half to 0x101 -> o_misaligned=1 one cycle after acceptance; a subsequent word load from 0x100 returns 0xDEADBEEF.
REQ-038 Store byte 0x5A to 0x10002001 -> o_io_out channel 2 =0x00005A00 and o_rsp_valid one cycle after acceptance; store to 0x10007000 with NUM_IO_OUT=5 -> all channels unchanged.
REQ-039 Set i_io_sw=0x0000_0081 and wait 2 cycles, then load byte signed from 0x10010000 -> o_ld_data=0xFFFFFF81.
REQ-040 Assert reset during MEM_WAIT of a store to 0x200 -> o_req_ready=1 after release and a load from 0x200 returns its pre-store value.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the multi-cycle load/store unit: access size
// encoding, FSM states, address-map bit positions and byte-lane helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_WORDX = 2'b11   // reserved encoding, behaves as a word
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RESP     = 2'd2
    } state_e;

    // Address map: bit 28 splits memory from IO, bit 16 picks the switches
    // inside IO space, bits 14:12 pick an output channel.
    localparam int ADDR_IO_BIT = 28;
    localparam int ADDR_SW_BIT = 16;
    localparam int ADDR_CH_LO  = 12;
    localparam int ADDR_CH_HI  = 14;

    // Request fields captured on acceptance.
    typedef struct packed {
        logic [31:0] addr;
        logic        wren;
        size_e       size;
        logic        uns;
        logic [31:0] data;
    } req_t;

    function automatic logic [3:0] byte_mask(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    // Right-align the addressed bytes, then sign- or zero-extend sub-words.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input size_e sz,
                                                 input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (sz)
            SZ_BYTE: return uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: return uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-maskable word memory with combinational read. Contents are not reset.
module lsu_dmem #(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [3:0][7:0] mem [MEM_WORDS];

    // Per-byte write under the lane mask
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) mem[i_idx][b] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = mem[i_idx];

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: one outstanding request, data memory with
// MEM_LAT wait cycles, IO output channels and a synchronized switch input.
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS  = 4096,
    parameter int MEM_LAT    = 2,
    parameter int NUM_IO_OUT = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [31:0]              i_addr,
    input  logic                     i_wren,
    input  logic [1:0]               i_size,
    input  logic                     i_unsigned,
    input  logic [31:0]              i_st_data,
    output logic                     o_rsp_valid,
    output logic [31:0]              o_ld_data,
    output logic                     o_misaligned,
    input  logic [31:0]              i_io_sw,
    output logic [NUM_IO_OUT*32-1:0] o_io_out
);

    localparam int AW = $clog2(MEM_WORDS);

    state_e      state;
    logic [2:0]  wait_cnt;
    req_t        req;
    logic [31:0] sw_s1, sw_s2;
    logic [NUM_IO_OUT-1:0][31:0] io_q;

    // Incoming request decode (used only in IDLE)
    size_e       in_size;
    logic        accept, in_mis, in_io, in_sw;
    logic [2:0]  in_ch;
    logic [3:0]  in_be;
    logic [31:0] in_wdata, io_rd, io_word;

    assign in_size  = size_e'(i_size);
    assign accept   = (state == ST_IDLE) && i_req_valid;
    assign in_mis   = is_misaligned(in_size, i_addr[1:0]);
    assign in_io    = i_addr[ADDR_IO_BIT];
    assign in_sw    = i_addr[ADDR_SW_BIT];
    assign in_ch    = i_addr[ADDR_CH_HI:ADDR_CH_LO];
    assign in_be    = byte_mask(in_size, i_addr[1:0]);
    assign in_wdata = i_st_data << {i_addr[1:0], 3'b000};
    assign io_word  = in_sw ? sw_s2 : io_rd;

    // Channel read mux; unimplemented channels read as zero
    always_comb begin
        io_rd = '0;
        for (int k = 0; k < NUM_IO_OUT; k++) begin
            if (in_ch == 3'(k)) io_rd = io_q[k];
        end
    end

    // Memory side is driven from the latched request
    logic        mem_last, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    assign mem_last  = (state == ST_MEM_WAIT) && (wait_cnt == 3'(MEM_LAT - 1));
    assign mem_we    = mem_last && req.wren;
    assign mem_be    = byte_mask(req.size, req.addr[1:0]);
    assign mem_wdata = req.data << {req.addr[1:0], 3'b000};

    lsu_dmem #(.MEM_WORDS(MEM_WORDS)) u_dmem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_idx   (req.addr[AW+1:2]),
        .i_be    (mem_be),
        .i_wdata (mem_wdata),
        .o_rdata (mem_rdata)
    );

    // Output channels: each written on the acceptance edge of an aligned IO store
    for (genvar k = 0; k < NUM_IO_OUT; k++) begin : g_io
        logic        ch_we;
        logic [31:0] ch_q;

        assign ch_we = accept && i_wren && in_io && !in_sw && !in_mis && (in_ch == 3'(k));

        // Byte-masked channel register
        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                ch_q <= '0;
            end else if (ch_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (in_be[b]) ch_q[8*b +: 8] <= in_wdata[8*b +: 8];
                end
            end
        end

        assign io_q[k]              = ch_q;
        assign o_io_out[32*k +: 32] = ch_q;
    end

    // Two-flop synchronizer for the switch input
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= i_io_sw;
            sw_s2 <= sw_s1;
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            req          <= '0;
            o_rsp_valid  <= 1'b0;
            o_ld_data    <= '0;
            o_misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        req.addr <= i_addr;
                        req.wren <= i_wren;
                        req.size <= in_size;
                        req.uns  <= i_unsigned;
                        req.data <= i_st_data;
                        if (in_mis) begin
                            state        <= ST_RESP;
                            o_rsp_valid  <= 1'b1;
                            o_misaligned <= 1'b1;
                            o_ld_data    <= '0;
                        end else if (in_io) begin
                            state        <= ST_RESP;
                            o_rsp_valid  <= 1'b1;
                            o_misaligned <= 1'b0;
                            o_ld_data    <= i_wren ? '0
                                          : load_extract(io_word, in_size, i_addr[1:0], i_unsigned);
                        end else begin
                            state    <= ST_MEM_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_last) begin
                        state        <= ST_RESP;
                        wait_cnt     <= '0;
                        o_rsp_valid  <= 1'b1;
                        o_misaligned <= 1'b0;
                        o_ld_data    <= req.wren ? '0
                                      : load_extract(mem_rdata, req.size, req.addr[1:0], req.uns);
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    o_rsp_valid <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = (state == ST_IDLE);

    // Address bits above the memory index are only meaningful at decode time
    logic unused_addr;
    assign unused_addr = ^req.addr[31:AW+2];

endmodule
